// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// Read hits complete without a memory transaction; read misses and all stores go to memory.

module dcache_wt_line #(
  parameter int TAG_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fill,
  input  logic             upd,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [31:0]      data_in,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output logic [31:0]      data
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    valid <= 1'b0;
    else if (fill) valid <= 1'b1;
  end

  // Tag and data arrays are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (fill)        tag  <= tag_in;
    if (fill || upd) data <= data_in;
  end
endmodule

module dcache_wt #(
  parameter int NUM_LINES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  output logic        cpu_ready,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_dout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM_RD, MEM_WR} state_t;

  typedef struct packed {
    logic        wr;
    logic [29:0] waddr;
    logic [31:0] wdata;
  } req_t;

  state_t state, nxt;
  req_t   req;

  logic [NUM_LINES-1:0]            line_valid;
  logic [NUM_LINES-1:0][TAG_W-1:0] line_tag;
  logic [NUM_LINES-1:0][31:0]      line_data;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             accept, hit, fill_en, upd_en;
  logic [31:0]      line_wdata;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign cpu_ready  = (state == IDLE);
  assign accept     = cpu_req && cpu_ready && (cpu_mem_read || cpu_mem_write);
  assign req_idx    = req.waddr[IDX_W-1:0];
  assign req_tag    = req.waddr[29:IDX_W];
  assign hit        = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
  assign fill_en    = (state == MEM_RD) && mem_ack;
  assign upd_en     = (state == LOOKUP) && req.wr && hit;
  assign line_wdata = fill_en ? mem_rdata : req.wdata;

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    dcache_wt_line #(.TAG_W(TAG_W)) u_line (
      .clk     (clk),
      .reset   (reset),
      .fill    (fill_en && (req_idx == IDX_W'(g))),
      .upd     (upd_en && (req_idx == IDX_W'(g))),
      .tag_in  (req_tag),
      .data_in (line_wdata),
      .valid   (line_valid[g]),
      .tag     (line_tag[g]),
      .data    (line_data[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      req <= '0;
    else if (accept) req <= '{wr: cpu_mem_write, waddr: cpu_addr[31:2], wdata: cpu_din};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = LOOKUP;
      LOOKUP:  nxt = req.wr ? MEM_WR : (hit ? IDLE : MEM_RD);
      MEM_RD:  if (mem_ack) nxt = IDLE;
      MEM_WR:  if (mem_ack) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Registered CPU/memory outputs; mem_addr/we/wdata are loaded once at end of LOOKUP
  // and stay put for the whole transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_resp_valid <= 1'b0;
      cpu_dout       <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      hit_count      <= '0;
      miss_count     <= '0;
    end else begin
      cpu_resp_valid <= 1'b0;
      case (state)
        LOOKUP: begin
          if (!req.wr && hit) begin
            cpu_resp_valid <= 1'b1;
            cpu_dout       <= line_data[req_idx];
            if (hit_count != '1) hit_count <= hit_count + 32'd1;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= req.wr;
            mem_addr  <= {req.waddr, 2'b00};
            mem_wdata <= req.wdata;
            if (!req.wr && miss_count != '1) miss_count <= miss_count + 32'd1;
          end
        end
        MEM_RD: if (mem_ack) begin
          mem_req        <= 1'b0;
          cpu_resp_valid <= 1'b1;
          cpu_dout       <= mem_rdata;
        end
        MEM_WR: if (mem_ack) begin
          mem_req        <= 1'b0;
          cpu_resp_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_wt.sv
// Directed + random bench for dcache_wt against a line-array / word-memory reference model.
module tb_dcache_wt;
  localparam int NL = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_mem_read, cpu_mem_write;
  logic [31:0] cpu_addr, cpu_din;
  logic        cpu_ready, cpu_resp_valid;
  logic [31:0] cpu_dout;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  dcache_wt #(.NUM_LINES(NL)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid), .cpu_dout(cpu_dout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: cache contents per line plus a word-addressed backing memory.
  bit          m_valid [NL];
  logic [31:0] m_tag   [NL];
  logic [31:0] m_data  [NL];
  logic [31:0] mem_model [int unsigned];
  int unsigned m_hits, m_misses;
  logic [31:0] exp_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a / 4) % NL;
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (4 * NL);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    m_hits = 0; m_misses = 0; exp_dout = '0;
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_ready"},  32'(cpu_ready), 32'd1);
    chk({pfx, "_resp"},   32'(cpu_resp_valid), 32'd0);
    chk({pfx, "_dout"},   cpu_dout, 32'd0);
    chk({pfx, "_memreq"}, 32'(mem_req), 32'd0);
    chk({pfx, "_memwe"},  32'(mem_we), 32'd0);
    chk({pfx, "_maddr"},  mem_addr, 32'd0);
    chk({pfx, "_mwdata"}, mem_wdata, 32'd0);
    chk({pfx, "_hits"},   hit_count, 32'd0);
    chk({pfx, "_misses"}, miss_count, 32'd0);
  endtask

  // Entered at a negedge with the cache idle; returns at the negedge of the response cycle.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input int lat);
    int unsigned i;
    logic [31:0] t, rd;
    bit hit;
    i = idx_of(addr); t = tag_of(addr);
    hit = m_valid[i] && (m_tag[i] == t);
    chk("ready_before_req", 32'(cpu_ready), 32'd1);
    cpu_req = 1'b1; cpu_mem_write = wr;
    cpu_mem_read = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    cpu_addr = addr; cpu_din = wdata;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_addr = $urandom; cpu_din = $urandom;
    cpu_mem_read = 1'($urandom); cpu_mem_write = 1'($urandom);
    @(negedge clk);
    chk("lookup_ready", 32'(cpu_ready), 32'd0);
    chk("lookup_noresp", 32'(cpu_resp_valid), 32'd0);
    @(negedge clk);
    if (!wr && hit) begin
      m_hits++; exp_dout = m_data[i];
      chk("hit_resp", 32'(cpu_resp_valid), 32'd1);
      chk("hit_data", cpu_dout, exp_dout);
      chk("hit_no_mem", 32'(mem_req), 32'd0);
    end else begin
      if (!wr) m_misses++;
      if (wr && hit) m_data[i] = wdata;
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_we", 32'(mem_we), 32'(wr));
      chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
      if (wr) chk("mem_wdata", mem_wdata, wdata);
      repeat (lat) begin
        @(negedge clk);
        chk("mem_req_held", 32'(mem_req), 32'd1);
        chk("no_early_resp", 32'(cpu_resp_valid), 32'd0);
      end
      if (wr) mem_model[addr / 4] = wdata;
      else if (!mem_model.exists(addr / 4)) mem_model[addr / 4] = $urandom;
      rd = wr ? $urandom : mem_model[addr / 4];
      mem_ack = 1'b1; mem_rdata = rd;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (!wr) begin
        exp_dout = rd; m_valid[i] = 1'b1; m_tag[i] = t; m_data[i] = rd;
      end
      chk("mem_resp", 32'(cpu_resp_valid), 32'd1);
      chk("mem_req_drop", 32'(mem_req), 32'd0);
      chk("mem_dout", cpu_dout, exp_dout);
    end
    chk("hit_count", hit_count, 32'(m_hits));
    chk("miss_count", miss_count, 32'(m_misses));
    chk("ready_in_resp", 32'(cpu_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b0; cpu_req = 1'b0; cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
    cpu_addr = '0; cpu_din = '0; mem_rdata = '0; mem_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset("por");
    reset = 1'b1;
    @(negedge clk);

    // Cold miss, then hit
    mem_model[32'h100 / 4] = 32'hDEAD_BEEF;
    access(1'b0, 32'h100, '0, 3);
    access(1'b0, 32'h100, '0, 0);
    // Write hit, then read back
    access(1'b1, 32'h100, 32'h1234_5678, 2);
    access(1'b0, 32'h102, '0, 0);
    // Conflict on index 0
    access(1'b0, 32'h140, '0, 1);
    access(1'b0, 32'h100, '0, 0);
    // No-write-allocate
    access(1'b1, 32'h200, 32'h55AA_55AA, 1);
    access(1'b0, 32'h200, '0, 2);

    // A strobe with neither read nor write is not accepted
    cpu_req = 1'b1; cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; cpu_addr = 32'h100;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("noop_ready", 32'(cpu_ready), 32'd1);
    chk("noop_memreq", 32'(mem_req), 32'd0);
    chk("noop_resp", 32'(cpu_resp_valid), 32'd0);
    access(1'b0, 32'h100, '0, 0);

    // Asynchronous reset mid-cycle
    #2 reset = 1'b0;
    #1 check_reset("async");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    access(1'b0, 32'h100, '0, 0);

    // Reset during MEM_RD, then a late ack
    cpu_req = 1'b1; cpu_mem_read = 1'b1; cpu_mem_write = 1'b0; cpu_addr = 32'h300;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midmiss_memreq", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1 chk("midmiss_drop", 32'(mem_req), 32'd0);
    chk("midmiss_noresp", 32'(cpu_resp_valid), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_resp", 32'(cpu_resp_valid), 32'd0);
    chk("late_ack_memreq", 32'(mem_req), 32'd0);
    chk("late_ack_ready", 32'(cpu_ready), 32'd1);
    access(1'b0, 32'h300, '0, 1);

    // Random traffic over a few tags so hits, conflicts and write hits all occur
    for (int n = 0; n < 120; n++) begin
      logic [31:0] a;
      a = 32'h1000 + ($urandom_range(0, 2) * 4 * NL) + ($urandom_range(0, NL - 1) * 4)
          + $urandom_range(0, 3);
      access($urandom_range(0, 9) < 3, a, $urandom, $urandom_range(0, 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
